// File: rtl/vector_pair_sequencer_pkg.sv
// rtl/vector_pair_sequencer_pkg.sv - shared constants and FSM encoding for the vector pair sequencer
package vector_pair_sequencer_pkg;

   localparam int VEC_LEN_DEF = 264;
   localparam int IDX_W_DEF   = 9;
   localparam int DATA_W_DEF  = 16;

   // Address-mapper second-operand select values
   localparam logic ALT_VEC2 = 1'b0;
   localparam logic ALT_VEC3 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/vector_pair_sequencer_pair_fifo.sv
// rtl/vector_pair_sequencer_pair_fifo.sv - circular pair buffer with occupancy count
module pair_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign pop_ok   = pop && !empty;
   // A full buffer can still accept a push when the head leaves in the same cycle
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/vector_pair_sequencer.sv
// rtl/vector_pair_sequencer.sv - walks two activation vectors and streams element pairs downstream
module vector_pair_sequencer
   import vector_pair_sequencer_pkg::*;
#(
   parameter int VEC_LEN    = VEC_LEN_DEF,
   parameter int IDX_W      = IDX_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              alt_sel,
   output logic [IDX_W-1:0]  vector_index,
   output logic              alt_address,
   output logic              rd_en,
   input  logic [DATA_W-1:0] rd_data1,
   input  logic [DATA_W-1:0] rd_data2,
   output logic              pair_valid,
   input  logic              pair_ready,
   output logic [DATA_W-1:0] pair_a,
   output logic [DATA_W-1:0] pair_b,
   output logic              pair_last,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PW    = 2 * DATA_W + 1;

   state_e            state;
   logic [RD_LAT-1:0] tag_v;
   logic [RD_LAT-1:0] tag_l;
   logic [2:0]        inflight;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [PW-1:0]     fifo_out;
   logic              pop;
   logic              last_seen;
   int                used;

   assign pop        = pair_valid && pair_ready;
   assign pair_valid = !fifo_empty;
   assign pair_a     = fifo_out[PW-1:DATA_W+1];
   assign pair_b     = fifo_out[DATA_W:1];
   assign pair_last  = !fifo_empty && fifo_out[0];
   assign busy       = (state == ST_ISSUE) || (state == ST_DRAIN);
   assign done       = (state == ST_DONE);

   // Credit: a slot freed by this cycle's pop may be reused by this cycle's read
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + 3'(tag_v[i]);
      end
      used  = int'(inflight) + int'(fifo_count) - int'(pop);
      rd_en = (state == ST_ISSUE) && (used < FIFO_DEPTH) && !fifo_full;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v <= '0;
         tag_l <= '0;
      end else begin
         tag_v[0] <= rd_en;
         tag_l[0] <= rd_en && (vector_index == IDX_W'(VEC_LEN - 1));
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_l[i] <= tag_l[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         vector_index <= '0;
         alt_address  <= ALT_VEC2;
         last_seen    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state        <= ST_ISSUE;
                  vector_index <= '0;
                  alt_address  <= alt_sel;
                  last_seen    <= 1'b0;
               end
            end
            ST_ISSUE: begin
               if (rd_en) begin
                  vector_index <= vector_index + 1'b1;
                  if (vector_index == IDX_W'(VEC_LEN - 1)) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if ((tag_v == '0) && fifo_empty && last_seen) begin
                  state <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (pop && pair_last) begin
            last_seen <= 1'b1;
         end
      end
   end

   pair_fifo #(
      .WIDTH (PW),
      .DEPTH (FIFO_DEPTH)
   ) u_pair_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (tag_v[RD_LAT-1]),
      .push_data ({rd_data1, rd_data2, tag_l[RD_LAT-1]}),
      .pop       (pop),
      .pop_data  (fifo_out),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule
